// File: rtl/cache_line_transfer.sv
// cache_line_transfer: memory-side engine for a single cache line.
// On a start request it writes the victim line back to memory if it is
// dirty, refills the line word by word from memory, then commits the new
// tag and tick so the line becomes valid and clean.
module cache_line_transfer #(
   parameter int unsigned TAG_WIDTH  = 26,
   parameter int unsigned SET_WIDTH  = 2,
   parameter int unsigned LINE_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   // controller side
   input  logic                  start,
   input  logic [TAG_WIDTH-1:0]  new_tag,
   input  logic [SET_WIDTH-1:0]  set_idx,
   input  logic [31:0]           now_tick,
   output logic                  busy,
   output logic                  done,
   // cache line side
   input  logic                  line_dirty,
   input  logic [TAG_WIDTH-1:0]  line_tag,
   input  logic [31:0]           line_out,
   output logic [LINE_WIDTH-1:0] line_index,
   output logic [31:0]           line_data,
   output logic [TAG_WIDTH-1:0]  line_set_tag,
   output logic [31:0]           line_set_tick,
   output logic [2:0]            line_ctrl,
   // memory bus side
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ready
);

   localparam int unsigned CNT_WIDTH = LINE_WIDTH - 2;
   localparam int unsigned LINE_SIZE = 2 ** CNT_WIDTH;

   // line_ctrl encodings: {tick_en, update_en, write_en}
   localparam logic [2:0] CTRL_WRITE  = 3'b001;
   localparam logic [2:0] CTRL_COMMIT = 3'b110;

   typedef enum logic [2:0] {
      IDLE,
      WB,
      FILL,
      COMMIT,
      DONE
   } state_t;

   state_t                 state;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [TAG_WIDTH-1:0]   tag_l;
   logic [SET_WIDTH-1:0]   set_l;
   logic [TAG_WIDTH-1:0]   vtag_l;
   logic                   dirty_l;
   logic [31:0]            tick_l;
   logic                   last_word;

   assign last_word = (cnt == CNT_WIDTH'(LINE_SIZE - 1));

   // Transfer sequencing: latch the request, step the word counter on each
   // completed memory word, and walk WB -> FILL -> COMMIT -> DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         tag_l   <= '0;
         set_l   <= '0;
         vtag_l  <= '0;
         dirty_l <= 1'b0;
         tick_l  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  tag_l   <= new_tag;
                  set_l   <= set_idx;
                  tick_l  <= now_tick;
                  vtag_l  <= line_tag;
                  dirty_l <= line_dirty;
                  cnt     <= '0;
                  state   <= line_dirty ? WB : FILL;
               end
            end
            WB: begin
               if (mem_ready) begin
                  // counter wraps to 0 on the last word, ready for FILL
                  cnt <= cnt + CNT_WIDTH'(1);
                  if (last_word) begin
                     state <= FILL;
                  end
               end
            end
            FILL: begin
               if (mem_ready) begin
                  cnt <= cnt + CNT_WIDTH'(1);
                  if (last_word) begin
                     state <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output decode from state, counter and latched request; everything is
   // zero outside the states that drive it, so reset clears all outputs.
   always_comb begin
      busy          = (state != IDLE);
      done          = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      line_index    = '0;
      line_data     = '0;
      line_set_tag  = '0;
      line_set_tick = '0;
      line_ctrl     = '0;
      case (state)
         WB: begin
            // WB is only entered with a dirty victim, so dirty_l is set here
            mem_req    = 1'b1;
            mem_we     = dirty_l;
            mem_addr   = {vtag_l, set_l, cnt, 2'b00};
            mem_wdata  = line_out;
            line_index = {cnt, 2'b00};
         end
         FILL: begin
            mem_req    = 1'b1;
            mem_addr   = {tag_l, set_l, cnt, 2'b00};
            line_index = {cnt, 2'b00};
            if (mem_ready) begin
               line_ctrl = CTRL_WRITE;
               line_data = mem_rdata;
            end
         end
         COMMIT: begin
            line_ctrl     = CTRL_COMMIT;
            line_set_tag  = tag_l;
            line_set_tick = tick_l;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_cache_line_transfer.sv
// Scoreboard bench for cache_line_transfer (T=26, S=2, B=4, 4 words/line).
module tb_cache_line_transfer;

   localparam int EV_MWR  = 0;
   localparam int EV_MRD  = 1;
   localparam int EV_LWR  = 2;
   localparam int EV_COM  = 3;
   localparam int EV_DONE = 4;
   localparam int EV_BAD  = 5;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [25:0] new_tag;
   logic [1:0]  set_idx;
   logic [31:0] now_tick;
   logic        busy;
   logic        done;
   logic        line_dirty;
   logic [25:0] line_tag;
   logic [31:0] line_out;
   logic [3:0]  line_index;
   logic [31:0] line_data;
   logic [25:0] line_set_tag;
   logic [31:0] line_set_tick;
   logic [2:0]  line_ctrl;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   ev_t exp_q[$];
   int  vectors     = 0;
   int  miscompares = 0;
   int  cyc         = 0;
   int  start_cyc   = 0;
   int  stall       = 0;
   int  wait_cnt    = 0;
   logic        pend = 1'b0;
   logic [64:0] held;

   cache_line_transfer #(
      .TAG_WIDTH (26),
      .SET_WIDTH (2),
      .LINE_WIDTH(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .new_tag      (new_tag),
      .set_idx      (set_idx),
      .now_tick     (now_tick),
      .busy         (busy),
      .done         (done),
      .line_dirty   (line_dirty),
      .line_tag     (line_tag),
      .line_out     (line_out),
      .line_index   (line_index),
      .line_data    (line_data),
      .line_set_tag (line_set_tag),
      .line_set_tick(line_set_tick),
      .line_ctrl    (line_ctrl),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // memory returns address ^ 0xFFFF0000; victim word = 0xD0 + byte index
   assign mem_rdata = mem_addr ^ 32'hFFFF_0000;
   assign line_out  = 32'h0000_00D0 + 32'(line_index);

   // ready driver: tied high, or low for 'stall' cycles before every word
   always @(posedge clk) begin
      #1;
      if (mem_req && (wait_cnt < stall)) begin
         mem_ready = 1'b0;
         wait_cnt++;
      end else begin
         mem_ready = 1'b1;
         wait_cnt  = 0;
      end
   end

   function automatic string kname(input int k);
      case (k)
         EV_MWR:  return "mem_write";
         EV_MRD:  return "mem_read";
         EV_LWR:  return "line_write";
         EV_COM:  return "commit";
         EV_DONE: return "done_latency";
         default: return "bad_ctrl";
      endcase
   endfunction

   task automatic check_ev(input int k, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected %s: got a=%h d=%h, required no event", kname(k), a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.a !== a || e.d !== d) begin
            miscompares++;
            $display("FAIL %s: got %s a=%h d=%h, required %s a=%h d=%h",
                     kname(e.kind), kname(k), a, d, kname(e.kind), e.a, e.d);
         end
      end
   endtask

   // monitor: pops the scoreboard whenever the DUT presents an event
   always @(negedge clk) begin
      if (reset) begin
         if (mem_req && mem_ready)
            check_ev(mem_we ? EV_MWR : EV_MRD, mem_addr, mem_we ? mem_wdata : 32'd0);
         if (line_ctrl == 3'b001)
            check_ev(EV_LWR, 32'(line_index), line_data);
         else if (line_ctrl == 3'b110)
            check_ev(EV_COM, 32'(line_set_tag), line_set_tick);
         else if (line_ctrl != 3'b000)
            check_ev(EV_BAD, 32'(line_ctrl), 32'd0);
         if (done)
            check_ev(EV_DONE, 32'd0, 32'(cyc - start_cyc));
         if (pend && mem_req) begin
            vectors++;
            if ({mem_we, mem_addr, mem_wdata} !== held) begin
               miscompares++;
               $display("FAIL hold: got we/addr/wdata=%h, required %h",
                        {mem_we, mem_addr, mem_wdata}, held);
            end
         end
         pend = mem_req && !mem_ready;
         held = {mem_we, mem_addr, mem_wdata};
      end else begin
         pend = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.a    = a;
      e.d    = d;
      exp_q.push_back(e);
   endtask

   // expected event stream for one full transfer
   task automatic push_transfer(input logic [25:0] tag, input logic [1:0] set,
                                input logic [25:0] vtag, input logic dirty,
                                input logic [31:0] tick, input int lat);
      logic [31:0] addr;
      logic [1:0]  w2;
      if (dirty) begin
         for (int w = 0; w < 4; w++) begin
            w2   = 2'(w);
            addr = {vtag, set, w2, 2'b00};
            push(EV_MWR, addr, 32'h0000_00D0 + 32'(4 * w));
         end
      end
      for (int w = 0; w < 4; w++) begin
         w2   = 2'(w);
         addr = {tag, set, w2, 2'b00};
         push(EV_MRD, addr, 32'd0);
         push(EV_LWR, 32'(4 * w), addr ^ 32'hFFFF_0000);
      end
      push(EV_COM, 32'(tag), tick);
      push(EV_DONE, 32'd0, 32'(lat));
   endtask

   task automatic setup(input logic [25:0] tag, input logic [1:0] set,
                        input logic [25:0] vtag, input logic dirty, input logic [31:0] tick);
      new_tag    = tag;
      set_idx    = set;
      line_tag   = vtag;
      line_dirty = dirty;
      now_tick   = tick;
   endtask

   // one-cycle start pulse; returns one cycle after the start edge
   task automatic issue_start();
      start     = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   // wait for the scoreboard to empty, then check the engine is idle
   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got %0d events pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_idle: got busy=%b done=%b, required busy=0 done=0", name, busy, done);
      end
      repeat (3) tick();
   endtask

   task automatic check_zero(input string name);
      logic any;
      any = |{busy, done, mem_req, mem_we, mem_addr, mem_wdata, line_ctrl,
              line_index, line_data, line_set_tag, line_set_tick};
      vectors++;
      if (any !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: got busy=%b req=%b ctrl=%b addr=%h idx=%h, required all outputs 0",
                  name, busy, mem_req, line_ctrl, mem_addr, line_index);
      end
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      mem_ready = 1'b1;
      setup(26'h0, 2'd0, 26'h0, 1'b0, 32'h0);
      #12;
      check_zero("reset_state");
      @(negedge clk);
      reset = 1'b1;
      tick();

      // clean fill
      setup(26'h0000ABC, 2'd1, 26'h0000777, 1'b0, 32'h0000_0011);
      push_transfer(26'h0000ABC, 2'd1, 26'h0000777, 1'b0, 32'h0000_0011, 6);
      issue_start();
      drain("clean");

      // dirty writeback then fill
      setup(26'h0000ABC, 2'd0, 26'h0000123, 1'b1, 32'h0000_0022);
      push_transfer(26'h0000ABC, 2'd0, 26'h0000123, 1'b1, 32'h0000_0022, 10);
      issue_start();
      drain("dirty");

      // stalls of 3 cycles before every word, clean then dirty
      stall = 3;
      setup(26'h00003A5, 2'd2, 26'h0000001, 1'b0, 32'h0000_0033);
      push_transfer(26'h00003A5, 2'd2, 26'h0000001, 1'b0, 32'h0000_0033, 18);
      issue_start();
      drain("stall_clean");
      setup(26'h000001F, 2'd3, 26'h0002222, 1'b1, 32'h0000_0044);
      push_transfer(26'h000001F, 2'd3, 26'h0002222, 1'b1, 32'h0000_0044, 34);
      issue_start();
      drain("stall_dirty");
      stall = 0;

      // start held high for the whole transfer
      setup(26'h0001234, 2'd2, 26'h0, 1'b0, 32'h0000_0066);
      push_transfer(26'h0001234, 2'd2, 26'h0, 1'b0, 32'h0000_0066, 6);
      start     = 1'b1;
      start_cyc = cyc;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         #1;
         if (done) break;
      end
      start = 1'b0;
      drain("start_held");

      // start pulsed during FILL is ignored
      setup(26'h0000456, 2'd3, 26'h0, 1'b0, 32'h0000_0077);
      push_transfer(26'h0000456, 2'd3, 26'h0, 1'b0, 32'h0000_0077, 6);
      issue_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      drain("start_in_fill");

      // reset during FILL word 2, then a full rerun
      setup(26'h0000ABC, 2'd1, 26'h0, 1'b0, 32'h0000_0088);
      push_transfer(26'h0000ABC, 2'd1, 26'h0, 1'b0, 32'h0000_0088, 6);
      issue_start();
      tick();
      tick();
      #1;
      reset = 1'b0;
      #1;
      check_zero("reset_mid_fill");
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tick();
      push_transfer(26'h0000ABC, 2'd1, 26'h0, 1'b0, 32'h0000_0088, 6);
      issue_start();
      drain("after_reset");

      // commit tick is the one latched at start
      setup(26'h0000BEE, 2'd0, 26'h0000321, 1'b1, 32'h0000_0055);
      push_transfer(26'h0000BEE, 2'd0, 26'h0000321, 1'b1, 32'h0000_0055, 10);
      issue_start();
      tick();
      tick();
      now_tick = 32'h0000_0099;
      drain("commit_tick");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
